// File: rtl/pixel_to_stream_pkg.sv
// Shared types for the pixel-to-stream packer: FSM states, the FIFO word
// layout and the partial-word byte-enable helper.
package pix_stream_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int DATA_W         = 8 * BYTES_PER_WORD;

  typedef enum logic [1:0] {
    IDLE,
    FRAME,
    EOF,
    DROP
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0]         data;
    logic [BYTES_PER_WORD-1:0] keep;
    logic                      user;
    logic                      last;
  } word_t;

  // Byte enables for a word holding n low-order bytes.
  function automatic logic [BYTES_PER_WORD-1:0] keep_mask(input logic [1:0] n);
    return 4'((5'd1 << n) - 5'd1);
  endfunction

endpackage

// File: rtl/pixel_to_stream_if.sv
// AXI4-Stream-style word channel between the pixel packer and the
// USB/UVC packetiser.
interface pixel_to_stream_if;
  import pix_stream_pkg::*;

  logic [DATA_W-1:0]         tdata;
  logic [BYTES_PER_WORD-1:0] tkeep;
  logic                      tuser;
  logic                      tlast;
  logic                      tvalid;
  logic                      tready;

  modport master (output tdata, tkeep, tuser, tlast, tvalid, input tready);
  modport slave  (input tdata, tkeep, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/pixel_to_stream_fifo.sv
// Single-clock word FIFO; data is read straight from the storage flops so a
// pushed word is visible one cycle after the push.
module stream_fifo #(
  parameter int WIDTH = 38,
  parameter int DEPTH = 64
) (
  input  logic             pixel_clk,
  input  logic             pixel_rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge pixel_clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pixel_to_stream.sv
// Packs the top 8 bits of each pixel four to a word and streams frames out
// through a FIFO; a full FIFO abandons the rest of the frame.
module pixel_to_stream
  import pix_stream_pkg::*;
#(
  parameter int DT_WIDTH   = 10,
  parameter int FIFO_DEPTH = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 pixel_clk,
  input  logic                 pixel_rst_n,
  input  logic                 pixel_fv,
  input  logic                 pixel_lv,
  input  logic [DT_WIDTH-1:0]  pixel_data,
  pixel_to_stream_if.master    m_axis,
  input  logic                 ovf_clr,
  output logic                 overflow,
  output logic [CNT_WIDTH-1:0] frame_cnt,
  output logic [CNT_WIDTH-1:0] drop_cnt
);

  state_t            state, state_nxt;
  logic              fv_d, lv_d;
  logic [1:0]        idx;
  logic [DATA_W-1:0] word_buf;
  word_t             pend;
  logic              pend_valid;
  logic              sof_pending;

  logic              fv_rise, fv_fall, lv_fall;
  logic              capture, flush, word_done;
  logic [7:0]        pix8;
  logic [DATA_W-1:0] cap_word;
  word_t             done_word, push_word, rd_word;
  logic              push, ovf_event, fifo_full, fifo_empty;

  assign pix8 = pixel_data[DT_WIDTH-1 -: 8];

  if (DT_WIDTH > 8) begin : g_unused
    logic unused_low_bits;
    assign unused_low_bits = ^pixel_data[DT_WIDTH-9:0];
  end

  always_comb begin
    fv_rise   = pixel_fv & ~fv_d;
    fv_fall   = ~pixel_fv & fv_d;
    lv_fall   = lv_d & ~pixel_lv;
    capture   = (state == FRAME) & pixel_fv & pixel_lv;
    flush     = (state == FRAME) & (lv_fall | fv_fall) & (idx != 2'd0);
    word_done = (capture & (idx == 2'd3)) | flush;

    cap_word = word_buf;
    cap_word[{idx, 3'b000} +: 8] = pix8;

    done_word      = '0;
    done_word.data = capture ? cap_word : word_buf;
    done_word.keep = capture ? 4'hF : keep_mask(idx);
    done_word.user = sof_pending;

    // A new word displaces the held one; the held one only gets tlast at EOF.
    push      = 1'b0;
    push_word = pend;
    if (word_done && pend_valid) begin
      push           = 1'b1;
      push_word.last = 1'b0;
    end else if (state == EOF && pend_valid) begin
      push           = 1'b1;
      push_word.last = 1'b1;
    end
    ovf_event = push & fifo_full;

    state_nxt = state;
    case (state)
      IDLE:    if (fv_rise) state_nxt = FRAME;
      FRAME:   if (ovf_event) state_nxt = DROP;
               else if (fv_fall) state_nxt = EOF;
      EOF:     state_nxt = ovf_event ? DROP : IDLE;
      DROP:    if (!pixel_fv) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      state       <= IDLE;
      fv_d        <= 1'b1;
      lv_d        <= 1'b0;
      idx         <= '0;
      word_buf    <= '0;
      pend        <= '0;
      pend_valid  <= 1'b0;
      sof_pending <= 1'b0;
      overflow    <= 1'b0;
      frame_cnt   <= '0;
      drop_cnt    <= '0;
    end else begin
      state <= state_nxt;
      fv_d  <= pixel_fv;
      lv_d  <= pixel_lv;

      if (state == IDLE && fv_rise) begin
        idx         <= '0;
        word_buf    <= '0;
        sof_pending <= 1'b1;
      end else if (word_done) begin
        idx         <= '0;
        word_buf    <= '0;
        sof_pending <= 1'b0;
      end else if (capture) begin
        idx      <= idx + 1'b1;
        word_buf <= cap_word;
      end

      if (ovf_event) begin
        pend_valid <= 1'b0;
      end else if (word_done) begin
        pend       <= done_word;
        pend_valid <= 1'b1;
      end else if (state == EOF) begin
        pend_valid <= 1'b0;
      end

      if (ovf_event)    overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;

      if (ovf_event) drop_cnt <= drop_cnt + CNT_WIDTH'(1);
      if (state == EOF && pend_valid && !fifo_full)
        frame_cnt <= frame_cnt + CNT_WIDTH'(1);
    end
  end

  stream_fifo #(
    .WIDTH ($bits(word_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .pixel_clk   (pixel_clk),
    .pixel_rst_n (pixel_rst_n),
    .wr_en       (push & ~fifo_full),
    .wr_data     (push_word),
    .rd_en       (m_axis.tvalid & m_axis.tready),
    .rd_data     (rd_word),
    .full        (fifo_full),
    .empty       (fifo_empty)
  );

  assign m_axis.tvalid = ~fifo_empty;
  assign m_axis.tdata  = rd_word.data;
  assign m_axis.tkeep  = rd_word.keep;
  assign m_axis.tuser  = rd_word.user;
  assign m_axis.tlast  = rd_word.last;

endmodule

// File: tb/tb_pixel_to_stream.sv
// Directed bench for pixel_to_stream with a 4-word FIFO so overflow and
// backpressure are reachable with short frames.
module tb_pixel_to_stream;
  import pix_stream_pkg::*;

  logic        pixel_clk = 1'b0;
  logic        pixel_rst_n;
  logic        pixel_fv, pixel_lv;
  logic [9:0]  pixel_data;
  logic        ovf_clr;
  logic        overflow;
  logic [15:0] frame_cnt, drop_cnt;

  int errors = 0;
  int checks = 0;
  int unstable = 0;
  int stall_seen = 0;
  bit prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  word_t rx_q[$];
  word_t exp_q[$];

  pixel_to_stream_if m_axis ();

  pixel_to_stream #(
    .DT_WIDTH   (10),
    .FIFO_DEPTH (4),
    .CNT_WIDTH  (16)
  ) dut (
    .pixel_clk   (pixel_clk),
    .pixel_rst_n (pixel_rst_n),
    .pixel_fv    (pixel_fv),
    .pixel_lv    (pixel_lv),
    .pixel_data  (pixel_data),
    .m_axis      (m_axis),
    .ovf_clr     (ovf_clr),
    .overflow    (overflow),
    .frame_cnt   (frame_cnt),
    .drop_cnt    (drop_cnt)
  );

  always #5 pixel_clk = ~pixel_clk;

  // Record accepted beats and watch that stalled data does not move.
  always @(negedge pixel_clk) begin
    word_t beat;
    if (pixel_rst_n) begin
      if (prev_stall && m_axis.tvalid && m_axis.tdata !== prev_data) unstable++;
      prev_stall = m_axis.tvalid && !m_axis.tready;
      if (prev_stall) stall_seen++;
      prev_data = m_axis.tdata;
      if (m_axis.tvalid && m_axis.tready) begin
        beat = '{data: m_axis.tdata, keep: m_axis.tkeep, user: m_axis.tuser, last: m_axis.tlast};
        rx_q.push_back(beat);
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step_cycle(input bit toggle);
    @(posedge pixel_clk);
    #1;
    if (toggle) m_axis.tready = ~m_axis.tready;
  endtask

  task automatic add_exp(input logic [31:0] data, input logic [3:0] keep,
                         input logic user, input logic last);
    exp_q.push_back('{data: data, keep: keep, user: user, last: last});
  endtask

  // One frame: lines of ppl pixels, value start+step*k; fused drops fv and lv together.
  task automatic applyStimulus(input int lines, input int ppl, input logic [9:0] start,
                               input int step, input bit fused, input bit toggle);
    int k = 0;
    pixel_fv = 1'b1; pixel_lv = 1'b0;
    step_cycle(toggle); step_cycle(toggle);
    for (int l = 0; l < lines; l++) begin
      for (int p = 0; p < ppl; p++) begin
        pixel_lv   = 1'b1;
        pixel_data = 10'(start + 10'(step * k));
        k++;
        step_cycle(toggle);
      end
      if (!(fused && l == lines - 1)) begin
        pixel_lv = 1'b0; pixel_data = '0;
        repeat (3) step_cycle(toggle);
      end
    end
    pixel_fv = 1'b0; pixel_lv = 1'b0; pixel_data = '0;
    repeat (3) step_cycle(toggle);
  endtask

  task automatic drain(input bit toggle);
    int idle = 0;
    int n = 0;
    while (idle < 4 && n < 400) begin
      if (m_axis.tvalid) idle = 0; else idle++;
      step_cycle(toggle);
      n++;
    end
    m_axis.tready = 1'b1;
    checkOutput("drain_done", 64'(idle >= 4), 64'd1);
  endtask

  task automatic compare_beats(input string tag);
    checkOutput({tag, "_count"}, 64'(rx_q.size()), 64'(exp_q.size()));
    foreach (exp_q[i]) begin
      if (i < rx_q.size()) begin
        checkOutput($sformatf("%s_w%0d_data", tag, i), 64'(rx_q[i].data), 64'(exp_q[i].data));
        checkOutput($sformatf("%s_w%0d_ctl", tag, i),
                    64'({rx_q[i].keep, rx_q[i].user, rx_q[i].last}),
                    64'({exp_q[i].keep, exp_q[i].user, exp_q[i].last}));
      end
    end
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    pixel_rst_n = 1'b0; pixel_fv = 1'b0; pixel_lv = 1'b0; pixel_data = '0;
    ovf_clr = 1'b0; m_axis.tready = 1'b1;
    repeat (3) @(posedge pixel_clk);
    #1;
    checkOutput("rst_tvalid", 64'(m_axis.tvalid), 64'd0);
    checkOutput("rst_tdata", 64'(m_axis.tdata), 64'd0);
    checkOutput("rst_overflow", 64'(overflow), 64'd0);
    checkOutput("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    checkOutput("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    pixel_rst_n = 1'b1;
    step_cycle(0);

    $display("[TB] two lines of eight pixels");
    applyStimulus(2, 8, 10'h3FC, 8, 1'b0, 1'b0);
    drain(1'b0);
    add_exp(32'h050301FF, 4'hF, 1'b1, 1'b0);
    add_exp(32'h0D0B0907, 4'hF, 1'b0, 1'b0);
    add_exp(32'h1513110F, 4'hF, 1'b0, 1'b0);
    add_exp(32'h1D1B1917, 4'hF, 1'b0, 1'b1);
    compare_beats("frame8x2");
    checkOutput("frame8x2_frame_cnt", 64'(frame_cnt), 64'd1);

    $display("[TB] six-pixel line, partial flush on line end");
    applyStimulus(1, 6, 10'h100, 4, 1'b0, 1'b0);
    drain(1'b0);
    add_exp(32'h43424140, 4'hF, 1'b1, 1'b0);
    add_exp(32'h00004544, 4'h3, 1'b0, 1'b1);
    compare_beats("line6");
    checkOutput("line6_frame_cnt", 64'(frame_cnt), 64'd2);

    $display("[TB] fv falls with the last of five pixels");
    applyStimulus(1, 5, 10'h200, 4, 1'b1, 1'b0);
    drain(1'b0);
    add_exp(32'h83828180, 4'hF, 1'b1, 1'b0);
    add_exp(32'h00000084, 4'h1, 1'b0, 1'b1);
    compare_beats("fused5");
    checkOutput("fused5_frame_cnt", 64'(frame_cnt), 64'd3);

    $display("[TB] overflow with consumer stalled");
    m_axis.tready = 1'b0;
    applyStimulus(1, 32, 10'h000, 4, 1'b0, 1'b0);
    checkOutput("ovf_flag", 64'(overflow), 64'd1);
    checkOutput("ovf_drop_cnt", 64'(drop_cnt), 64'd1);
    checkOutput("ovf_frame_cnt", 64'(frame_cnt), 64'd3);
    checkOutput("ovf_held_tvalid", 64'(m_axis.tvalid), 64'd1);
    m_axis.tready = 1'b1;
    drain(1'b0);
    add_exp(32'h03020100, 4'hF, 1'b1, 1'b0);
    add_exp(32'h07060504, 4'hF, 1'b0, 1'b0);
    add_exp(32'h0B0A0908, 4'hF, 1'b0, 1'b0);
    add_exp(32'h0F0E0D0C, 4'hF, 1'b0, 1'b0);
    compare_beats("ovf_held");
    applyStimulus(1, 8, 10'h040, 4, 1'b0, 1'b0);
    drain(1'b0);
    add_exp(32'h13121110, 4'hF, 1'b1, 1'b0);
    add_exp(32'h17161514, 4'hF, 1'b0, 1'b1);
    compare_beats("after_ovf");
    checkOutput("after_ovf_frame_cnt", 64'(frame_cnt), 64'd4);
    checkOutput("ovf_sticky", 64'(overflow), 64'd1);
    ovf_clr = 1'b1;
    step_cycle(0);
    ovf_clr = 1'b0;
    checkOutput("ovf_cleared", 64'(overflow), 64'd0);

    $display("[TB] reset released mid-frame");
    pixel_fv = 1'b1; step_cycle(0);
    pixel_lv = 1'b1;
    for (int k = 0; k < 3; k++) begin pixel_data = 10'(k * 4); step_cycle(0); end
    pixel_rst_n = 1'b0;
    step_cycle(0); step_cycle(0);
    checkOutput("midrst_tvalid", 64'(m_axis.tvalid), 64'd0);
    pixel_rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin pixel_data = 10'(k * 4 + 40); step_cycle(0); end
    pixel_lv = 1'b0; repeat (3) step_cycle(0);
    pixel_lv = 1'b1;
    for (int k = 0; k < 4; k++) begin pixel_data = 10'(k * 4 + 80); step_cycle(0); end
    pixel_lv = 1'b0; pixel_fv = 1'b0; pixel_data = '0;
    repeat (10) step_cycle(0);
    checkOutput("midrst_no_beats", 64'(rx_q.size()), 64'd0);
    checkOutput("midrst_frame_cnt", 64'(frame_cnt), 64'd0);
    checkOutput("midrst_drop_cnt", 64'(drop_cnt), 64'd0);
    applyStimulus(1, 4, 10'h3F0, 4, 1'b0, 1'b0);
    drain(1'b0);
    add_exp(32'hFFFEFDFC, 4'hF, 1'b1, 1'b1);
    compare_beats("post_rst");
    checkOutput("post_rst_frame_cnt", 64'(frame_cnt), 64'd1);

    $display("[TB] 64-pixel frame with tready toggling");
    applyStimulus(1, 64, 10'h000, 4, 1'b0, 1'b1);
    drain(1'b1);
    for (int j = 0; j < 16; j++)
      add_exp({8'(4*j+3), 8'(4*j+2), 8'(4*j+1), 8'(4*j)}, 4'hF, 1'(j == 0), 1'(j == 15));
    compare_beats("bp64");
    checkOutput("bp64_frame_cnt", 64'(frame_cnt), 64'd2);
    checkOutput("bp64_stall_seen", 64'(stall_seen > 0), 64'd1);
    checkOutput("bp64_stall_stable", 64'(unstable), 64'd0);
    checkOutput("bp64_overflow", 64'(overflow), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
